lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
- Load/store initiator between the pipeline MEM stage and the word-addressed data memory.
- Converts byte/halfword/word requests into word reads and writes on the memory port (mem_ad, wrtDat, memWrt, redDat).
- Performs read-modify-write for sub-word stores, splits word-crossing accesses, and sign/zero-extends load data.
- Single outstanding request; valid/ready handshake on the request side, one-cycle pulse on the response side.

Parameters:
- WORDS, 256, depth of the target memory in 32-bit words; used for the bounds check.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  synchronous reset, active-low; when low at posedge, all state is cleared.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid && req_ready at posedge.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = halfword, 2 = word; 3 is treated as word.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  one-cycle pulse when the request completes; no backpressure.
- resp_rdata  output  32  extended load data, valid with resp_valid; 0 for stores.
- resp_err  output  1  access fault, valid with resp_valid.
- mem_ad  output  32  memory byte address, always word-aligned ([1:0]=0).
- wrtDat  output  32  memory write word.
- memWrt  output  1  memory write enable.
- redDat  input  32  memory read word; combinational from mem_ad in the same cycle.

Behaviour:
- Reset (rst low at posedge): state goes to IDLE. resp_valid=0, resp_rdata=0, resp_err=0, memWrt=0, mem_ad=0, wrtDat=0. req_ready=0 while rst is low and 1 in IDLE afterwards. memWrt is never 1 in a cycle where rst is low.
- Reset mid-operation aborts the access with no response. A split store whose first word was already written leaves that word written.
- States: IDLE, RD0, WR0, RD1, WR1, RESP. req_ready=1 only in IDLE. The request is latched on acceptance.
- Address fields: off = addr[1:0]; w0 = addr[31:2]; w1 = w0+1 modulo 2^30. The access crosses a word boundary iff off + bytes > 4, where bytes = 1, 2 or 4.
- Bounds check: if w0 >= WORDS, or the access crosses and w1 >= WORDS, go IDLE->RESP with resp_err=1 and issue no memory access.
- Aligned word store: IDLE->WR0->RESP. WR0 drives mem_ad={w0,00}, wrtDat=wdata, memWrt=1.
- Sub-word or crossing store:
  - RD0 latches redDat into a merge register.
  - WR0 writes the little-endian byte-merged word.
  - If crossing, RD1 and WR1 do the same for w1 with the upper bytes.
  - Then RESP.
- Load: RD0 latches word0; RD1 latches word1 if crossing; then RESP.
- Load data: take the 64-bit value {word1,word0} shifted right by 8*off. Truncate to the size, then sign- or zero-extend per req_unsigned.
- memWrt=1 only in WR0 and WR1. mem_ad=0 and wrtDat=0 in IDLE and RESP.
- Latency from accept to resp_valid:
  - aligned load: 2 cycles.
  - aligned word store: 2 cycles.
  - aligned sub-word store: 3 cycles.
  - crossing load: 3 cycles.
  - crossing store: 5 cycles.
  - error: 1 cycle.
- RESP lasts exactly 1 cycle, then IDLE. A new request can be accepted the cycle after RESP.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- When defined, any access with a nonzero off (halfword with addr[0]=1, word with off!=0) is not executed. The FSM goes IDLE->RESP with resp_err=1, resp_rdata=0, and memWrt is never asserted. Crossing logic (RD1/WR1) is not built.
- When undefined, misaligned accesses are split as above and resp_err reflects only the bounds check.

Test Plan:
- mem[0]=0x8877_66F5; load byte signed addr 0x0 -> resp_rdata 0xFFFF_FFF5 two cycles after accept; unsigned -> 0x0000_00F5.
- mem[1]=0xAABB_CCDD; store byte 0x11 at addr 0x6 -> RD0 then WR0 with wrtDat 0xAA11_CCDD, memWrt high exactly 1 cycle; resp_err=0.
- mem[1]=0x4433_2211, mem[2]=0x8877_6655; load word addr 0x7 -> resp_rdata 0x7766_5544 at cycle 3. With MISALIGN_TRAP_EN: resp_err=1 at cycle 1, no memory read latched.
- Store word 0xDEAD_BEEF at addr 0x5 with mem[1]=mem[2]=0 -> mem[1]=0xADBE_EF00, mem[2]=0x0000_00DE, resp at cycle 5.
- WORDS=256, load addr 0x400 -> resp_err=1 one cycle after accept, memWrt never high; store addr 0x3FE halfword at the boundary succeeds.
- Crossing store, rst driven low in WR1 cycle -> mem[w0] updated, mem[w1] unchanged, no resp_valid, req_ready=1 the cycle after rst returns high.

Source files
------------

// File: rtl/lsu_mem_master_if.sv
// Request/response and data-memory signal bundle for the load/store initiator.
// The master modport is the initiator's view; the slave modport is pipeline plus memory.
interface lsu_mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_ad;
    logic [31:0] wrtDat;
    logic        memWrt;
    logic [31:0] redDat;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, redDat,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_ad, wrtDat, memWrt
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, redDat,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_ad, wrtDat, memWrt
    );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator: byte/half/word requests to word memory with RMW, word splitting and extension.
// Define MISALIGN_TRAP_EN to fault any misaligned access instead of splitting it.
module lsu_mem_master #(
    parameter int WORDS = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    lsu_mem_master_if.master      bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0, RD0 = 3'd1, WR0 = 3'd2, RD1 = 3'd3, WR1 = 3'd4, RESP = 3'd5
    } state_t;

    localparam logic [31:0] WORDS_U = 32'(WORDS);

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            2'd0:    size_bytes = 3'd1;
            2'd1:    size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

    function automatic logic crosses(input logic [1:0] off, input logic [1:0] sz);
`ifdef MISALIGN_TRAP_EN
        crosses = 1'b0 & off[0] & sz[0];
`else
        crosses = (3'({1'b0, off}) + size_bytes(sz)) > 3'd4;
`endif
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        merge_word = (old_w & ~m) | (new_w & m);
    endfunction

    state_t      state_r, state_nx_s;
    logic [31:0] addr_r, wdata_r, word0_r, word1_r;
    logic [1:0]  size_r;
    logic        we_r, uns_r, cross_r;
    logic        resp_valid_r, resp_err_r;
    logic [31:0] resp_rdata_r;

    logic [29:0] in_w0_s, in_w1_s, w0_s, w1_s;
    logic        in_cross_s, in_err_s, accept_s, wr_s;
    logic [3:0]  be4_s;
    logic [7:0]  be8_s;
    logic [63:0] data64_s;
    logic [31:0] lo_s, hi_s, ld_sh_s, ld_ext_s, mem_ad_s, wrt_s;

    // Classification of the incoming request, evaluated while IDLE.
    assign in_w0_s    = bus.req_addr[31:2];
    assign in_w1_s    = in_w0_s + 30'd1;
    assign in_cross_s = crosses(bus.req_addr[1:0], bus.req_size);
`ifdef MISALIGN_TRAP_EN
    assign in_err_s = ({2'b00, in_w0_s} >= WORDS_U) ||
                      ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                      (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
    assign in_err_s = ({2'b00, in_w0_s} >= WORDS_U) ||
                      (in_cross_s && ({2'b00, in_w1_s} >= WORDS_U));
`endif
    assign accept_s = (state_r == IDLE) && bus.req_valid;

    assign w0_s     = addr_r[31:2];
    assign w1_s     = w0_s + 30'd1;
    assign be4_s    = (size_r == 2'd0) ? 4'b0001 : ((size_r == 2'd1) ? 4'b0011 : 4'b1111);
    assign be8_s    = {4'b0000, be4_s} << addr_r[1:0];
    assign data64_s = {32'd0, wdata_r} << {addr_r[1:0], 3'b000};

    // Load data straight from the memory port in the cycle that completes the read.
    assign lo_s    = (state_r == RD0) ? bus.redDat : word0_r;
    assign hi_s    = (state_r == RD1) ? bus.redDat : word1_r;
    assign ld_sh_s = 32'({hi_s, lo_s} >> {addr_r[1:0], 3'b000});

    // Truncate the shifted load to its size and extend.
    always_comb begin
        ld_ext_s = ld_sh_s;
        case (size_r)
            2'd0:    ld_ext_s = uns_r ? {24'd0, ld_sh_s[7:0]}  : {{24{ld_sh_s[7]}}, ld_sh_s[7:0]};
            2'd1:    ld_ext_s = uns_r ? {16'd0, ld_sh_s[15:0]} : {{16{ld_sh_s[15]}}, ld_sh_s[15:0]};
            default: ld_ext_s = ld_sh_s;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_r <= IDLE;
        else      state_r <= state_nx_s;
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (!bus.req_valid)                                       state_nx_s = IDLE;
                else if (in_err_s)                                        state_nx_s = RESP;
                else if (bus.req_we && bus.req_size[1] && (bus.req_addr[1:0] == 2'b00))
                                                                          state_nx_s = WR0;
                else                                                      state_nx_s = RD0;
            end
            RD0:     state_nx_s = we_r ? WR0 : (cross_r ? RD1 : RESP);
            WR0:     state_nx_s = cross_r ? RD1 : RESP;
            RD1:     state_nx_s = we_r ? WR1 : RESP;
            WR1:     state_nx_s = RESP;
            RESP:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Memory-port outputs per state; word writes are byte-merged with the latched read.
    always_comb begin
        mem_ad_s = 32'd0;
        wrt_s    = 32'd0;
        wr_s     = 1'b0;
        case (state_r)
            RD0: mem_ad_s = {w0_s, 2'b00};
            WR0: begin
                mem_ad_s = {w0_s, 2'b00};
                wrt_s    = merge_word(word0_r, data64_s[31:0], be8_s[3:0]);
                wr_s     = 1'b1;
            end
            RD1: mem_ad_s = {w1_s, 2'b00};
            WR1: begin
                mem_ad_s = {w1_s, 2'b00};
                wrt_s    = merge_word(word1_r, data64_s[63:32], be8_s[7:4]);
                wr_s     = 1'b1;
            end
            default: begin
                mem_ad_s = 32'd0;
                wrt_s    = 32'd0;
                wr_s     = 1'b0;
            end
        endcase
    end

    // Request capture and memory read latches.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            size_r  <= 2'd0;
            we_r    <= 1'b0;
            uns_r   <= 1'b0;
            cross_r <= 1'b0;
            word0_r <= 32'd0;
            word1_r <= 32'd0;
        end else begin
            if (accept_s) begin
                addr_r  <= bus.req_addr;
                wdata_r <= bus.req_wdata;
                size_r  <= bus.req_size;
                we_r    <= bus.req_we;
                uns_r   <= bus.req_unsigned;
                cross_r <= in_cross_s;
            end
            if (state_r == RD0) word0_r <= bus.redDat;
            if (state_r == RD1) word1_r <= bus.redDat;
        end
    end

    // Registered response, loaded on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'd0;
        end else begin
            resp_valid_r <= (state_nx_s == RESP);
            resp_err_r   <= (state_r == IDLE) && (state_nx_s == RESP);
            resp_rdata_r <= ((state_nx_s == RESP) && ((state_r == RD0) || (state_r == RD1)))
                            ? ld_ext_s : 32'd0;
        end
    end

    // Write strobe and ready are gated so nothing happens while reset is held.
    assign bus.memWrt     = wr_s & rst;
    assign bus.req_ready  = (state_r == IDLE) & rst;
    assign bus.mem_ad     = mem_ad_s;
    assign bus.wrtDat     = wrt_s;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.resp_rdata = resp_rdata_r;
endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: byte-level reference memory model, randomized requests.
module tb_lsu_mem_master;
    localparam int WORDS = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lsu_mem_master_if bus ();
    lsu_mem_master #(.WORDS(WORDS)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nwr;
        int          acc;
    } exp_t;

    logic [31:0] mem_w [0:WORDS-1];
    logic [7:0]  refm  [0:4*WORDS-1];
    exp_t        sb [$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wr_cnt = 0;

    // Target memory: combinational read, write on posedge.
    assign bus.redDat = (bus.mem_ad[31:2] < 30'(WORDS)) ? mem_w[bus.mem_ad[9:2]] : 32'hDEAD_DEAD;
    always @(posedge clk) begin
        if (bus.memWrt && (bus.mem_ad[31:2] < 30'(WORDS))) mem_w[bus.mem_ad[9:2]] <= bus.wrtDat;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic set_word(input int k, input logic [31:0] v);
        mem_w[k] = v;
        for (int i = 0; i < 4; i++) refm[4*k+i] = v[8*i +: 8];
    endtask

    function automatic logic [31:0] ref_word(input int k);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = refm[4*k+i];
        return v;
    endfunction

    // Reference: byte-addressed memory, little-endian, latency from state path length.
    function automatic exp_t model(input bit we, input logic [1:0] sz, input bit uns,
                                   input logic [31:0] a, input logic [31:0] wd);
        exp_t   e;
        int     n, off;
        longint w;
        bit     cr;
        logic [63:0] v;
        n   = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
        off = int'(a % 4);
        w   = longint'(a / 4);
        cr  = (off + n) > 4;
        e.rdata = 32'd0;
        e.acc   = 0;
        e.err   = (w >= WORDS) || (cr && (w + 1 >= WORDS));
        if (e.err) begin
            e.lat = 1;
            e.nwr = 0;
        end else if (we) begin
            for (int i = 0; i < n; i++) refm[int'(a) + i] = wd[8*i +: 8];
            e.lat = cr ? 5 : ((n == 4) ? 2 : 3);
            e.nwr = cr ? 2 : 1;
        end else begin
            v = 64'd0;
            for (int i = 0; i < n; i++) v = v | (64'(refm[int'(a) + i]) << (8*i));
            if (!uns && v[8*n-1]) v = v | (~64'd0 << (8*n));
            e.rdata = v[31:0];
            e.lat   = cr ? 3 : 2;
            e.nwr   = 0;
        end
        return e;
    endfunction

    // Monitor: counts write strobes and checks each response against the queue head.
    always @(negedge clk) begin
        if (bus.memWrt) wr_cnt++;
        if (bus.resp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp actual=1 expected=0 rdata=%h", bus.resp_rdata);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_rdata", bus.resp_rdata, mon_e.rdata);
                chk("resp_err", 32'(bus.resp_err), 32'(mon_e.err));
                chk("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
                chk("write_count", 32'(wr_cnt), 32'(mon_e.nwr));
            end
            wr_cnt = 0;
        end
    end

    // Issue one request (called just after a negedge) and wait for its response.
    task automatic do_req(input bit we, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int   k;
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        k = 0;
        while (!bus.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=0 expected=1 addr=%h", a);
            bus.req_valid = 1'b0;
            return;
        end
        e     = model(we, sz, uns, a, wd);
        e.acc = cyc;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        k = 0;
        while (sb.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout actual=none expected=resp addr=%h", a);
            sb.delete();
        end
    endtask

    initial begin
        int          w, off;
        logic [31:0] a;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;
        for (int k = 0; k < WORDS; k++) set_word(k, $urandom);

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_memWrt", 32'(bus.memWrt), 32'd0);
        chk("rst_mem_ad", bus.mem_ad, 32'd0);
        chk("rst_wrtDat", bus.wrtDat, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", 32'(bus.req_ready), 32'd1);

        // Directed cases.
        set_word(0, 32'h8877_66F5);
        do_req(1'b0, 2'd0, 1'b0, 32'h0, 32'd0);
        do_req(1'b0, 2'd0, 1'b1, 32'h0, 32'd0);
        set_word(1, 32'hAABB_CCDD);
        do_req(1'b1, 2'd0, 1'b0, 32'h6, 32'h0000_0011);
        chk("sb_store_mem1", mem_w[1], 32'hAA11_CCDD);
        set_word(1, 32'h4433_2211);
        set_word(2, 32'h8877_6655);
        do_req(1'b0, 2'd2, 1'b0, 32'h7, 32'd0);
        set_word(1, 32'd0);
        set_word(2, 32'd0);
        do_req(1'b1, 2'd2, 1'b0, 32'h5, 32'hDEAD_BEEF);
        chk("xw_store_mem1", mem_w[1], 32'hADBE_EF00);
        chk("xw_store_mem2", mem_w[2], 32'h0000_00DE);
        do_req(1'b0, 2'd2, 1'b0, 32'h400, 32'd0);
        do_req(1'b1, 2'd1, 1'b0, 32'h3FE, 32'h0000_1234);
        do_req(1'b0, 2'd1, 1'b1, 32'h3FE, 32'd0);
        do_req(1'b1, 2'd1, 1'b0, 32'h3FF, 32'h0000_5678);
        do_req(1'b0, 2'd3, 1'b0, 32'h3FC, 32'd0);

        // Reset during WR1 of a crossing store.
        set_word(10, 32'h1111_1111);
        set_word(11, 32'h2222_2222);
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b1;
        bus.req_size     = 2'd2;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'd42;
        bus.req_wdata    = 32'hCAFE_F00D;
        while (!bus.req_ready) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("wr1_memWrt", 32'(bus.memWrt), 32'd1);
        chk("wr1_mem_ad", bus.mem_ad, 32'd44);
        #2 rst = 1'b0;
        #1;
        chk("rstlow_memWrt", 32'(bus.memWrt), 32'd0);
        chk("rstlow_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("after_rst_ready", 32'(bus.req_ready), 32'd1);
        chk("after_rst_resp", 32'(bus.resp_valid), 32'd0);
        chk("abort_mem_w0", mem_w[10], 32'hF00D_1111);
        chk("abort_mem_w1", mem_w[11], 32'h2222_2222);
        refm[42] = 8'h0D;
        refm[43] = 8'hF0;
        wr_cnt = 0;

        // Randomized traffic, concentrated near word boundaries and the top of memory.
        for (int t = 0; t < 200; t++) begin
            w   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(WORDS - 3, WORDS + 2))
                                              : int'($urandom_range(0, 15));
            off = int'($urandom_range(0, 3));
            a   = 32'(w * 4 + off);
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), a, $urandom);
        end

        // Final memory image against the reference.
        for (int k = 0; k < WORDS; k++) chk("final_mem", mem_w[k], ref_word(k));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
